// File: rtl/wb_sram_pkg.sv
// Shared types and constants for the Wishbone-to-SRAM byte bridge.
package wb_sram_pkg;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      ACK
   } state_t;

   localparam int LANES = 4;

   localparam logic [7:0] RAM_WEN_IDLE = 8'hFF;
   localparam logic [7:0] RAM_WEN_ALL  = 8'h00;

endpackage

// File: rtl/wb_sram_lane_pick.sv
// Lowest-set-bit picker over the byte-lane mask; 'none' flags an empty mask.
module wb_sram_lane_pick
   import wb_sram_pkg::*;
(
   input  logic [LANES-1:0] mask,
   output logic [1:0]       lane,
   output logic             none
);

   always_comb begin
      lane = 2'd0;
      none = (mask == '0);
      if (mask[0])
         lane = 2'd0;
      else if (mask[1])
         lane = 2'd1;
      else if (mask[2])
         lane = 2'd2;
      else if (mask[3])
         lane = 2'd3;
   end

endmodule

// File: rtl/wb_sram_bridge.sv
// Wishbone classic slave serialising 32-bit word accesses into byte
// operations on the 512x8 SRAM macro, one selected lane per cycle.
module wb_sram_bridge
   import wb_sram_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        wbs_cyc_i,
   input  logic        wbs_stb_i,
   input  logic        wbs_we_i,
   input  logic [3:0]  wbs_sel_i,
   input  logic [31:0] wbs_adr_i,
   input  logic [31:0] wbs_dat_i,
   output logic        wbs_ack_o,
   output logic [31:0] wbs_dat_o,
   output logic        ram_cen_o,
   output logic        ram_gwen_o,
   output logic [7:0]  ram_wen_o,
   output logic [8:0]  ram_a_o,
   output logic [7:0]  ram_d_o,
   input  logic [7:0]  ram_q_i
);

   state_t      state;
   logic [6:0]  adr_q;
   logic        we_q;
   logic [3:0]  pend;
   logic [31:0] dat_q;
   logic [31:0] rdata;
   logic        cap_valid;
   logic [1:0]  cap_lane;

   logic        hit;
   logic        req;
   logic [3:0]  pick_mask;
   logic [1:0]  pick_lane;
   logic        pick_none;
   logic [3:0]  lane_bit;
   logic [6:0]  src_adr;
   logic [31:0] src_dat;
   logic        src_we;
   logic [31:0] rdata_cap;
   logic        read_on_bus;
   logic        unused_adr_bits;

   assign unused_adr_bits = ^wbs_adr_i[1:0];

   // In IDLE the first lane is issued straight from the request so that
   // lane 0 is on the macro pins during the cycle after the accept edge.
   always_comb begin
      hit         = (wbs_adr_i[31:9] == BASE_ADDR[31:9]);
      req         = wbs_cyc_i & wbs_stb_i & hit;
      pick_mask   = (state == IDLE) ? wbs_sel_i : pend;
      src_adr     = (state == IDLE) ? wbs_adr_i[8:2] : adr_q;
      src_dat     = (state == IDLE) ? wbs_dat_i : dat_q;
      src_we      = (state == IDLE) ? wbs_we_i : we_q;
      lane_bit    = 4'b0001 << pick_lane;
      read_on_bus = !ram_cen_o && !we_q;
      rdata_cap   = rdata;
      if (cap_valid)
         rdata_cap[{cap_lane, 3'b000} +: 8] = ram_q_i;
   end

   wb_sram_lane_pick u_pick (
      .mask (pick_mask),
      .lane (pick_lane),
      .none (pick_none)
   );

   // Bus FSM plus registered macro pins; the macro defaults to idle each
   // cycle and is only enabled when a lane is issued.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state      <= IDLE;
         adr_q      <= '0;
         we_q       <= 1'b0;
         pend       <= '0;
         dat_q      <= '0;
         rdata      <= '0;
         cap_valid  <= 1'b0;
         cap_lane   <= '0;
         wbs_ack_o  <= 1'b0;
         wbs_dat_o  <= '0;
         ram_cen_o  <= 1'b1;
         ram_gwen_o <= 1'b1;
         ram_wen_o  <= RAM_WEN_IDLE;
         ram_a_o    <= '0;
         ram_d_o    <= '0;
      end else begin
         wbs_ack_o  <= 1'b0;
         wbs_dat_o  <= '0;
         ram_cen_o  <= 1'b1;
         ram_gwen_o <= 1'b1;
         ram_wen_o  <= RAM_WEN_IDLE;
         ram_a_o    <= '0;
         ram_d_o    <= '0;

         case (state)
            IDLE: begin
               if (req) begin
                  adr_q     <= wbs_adr_i[8:2];
                  we_q      <= wbs_we_i;
                  dat_q     <= wbs_dat_i;
                  rdata     <= '0;
                  cap_valid <= 1'b0;
                  pend      <= pick_mask & ~lane_bit;
                  state     <= BUSY;
                  if (!pick_none) begin
                     ram_cen_o  <= 1'b0;
                     ram_gwen_o <= ~src_we;
                     ram_wen_o  <= src_we ? RAM_WEN_ALL : RAM_WEN_IDLE;
                     ram_a_o    <= {src_adr, pick_lane};
                     ram_d_o    <= src_dat[{pick_lane, 3'b000} +: 8];
                  end
               end
            end

            BUSY: begin
               if (!wbs_cyc_i) begin
                  state     <= IDLE;
                  pend      <= '0;
                  cap_valid <= 1'b0;
               end else begin
                  rdata     <= rdata_cap;
                  cap_valid <= read_on_bus;
                  cap_lane  <= ram_a_o[1:0];
                  if (!pick_none) begin
                     pend       <= pend & ~lane_bit;
                     ram_cen_o  <= 1'b0;
                     ram_gwen_o <= ~src_we;
                     ram_wen_o  <= src_we ? RAM_WEN_ALL : RAM_WEN_IDLE;
                     ram_a_o    <= {src_adr, pick_lane};
                     ram_d_o    <= src_dat[{pick_lane, 3'b000} +: 8];
                  end else if (!read_on_bus) begin
                     state     <= ACK;
                     wbs_ack_o <= 1'b1;
                     wbs_dat_o <= rdata_cap;
                  end
               end
            end

            ACK: begin
               state <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wb_sram_bridge.sv
// Self-checking bench: cycle-level expected pin timeline built from the
// access timing rules, a shadow byte memory, and a behavioural SRAM macro.
module tb_wb_sram_bridge;

   localparam logic [31:0] BASE = 32'h3000_0000;

   typedef struct packed {
      logic        cen;
      logic        gwen;
      logic [7:0]  wen;
      logic [8:0]  a;
      logic [7:0]  d;
      logic        ack;
      logic [31:0] dat;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        cyc, stb, we;
   logic [3:0]  sel;
   logic [31:0] adr, dat;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;
   logic        ram_cen_o, ram_gwen_o;
   logic [7:0]  ram_wen_o;
   logic [8:0]  ram_a_o;
   logic [7:0]  ram_d_o;
   logic [7:0]  ram_q;

   logic [7:0]  sram     [512];
   logic [7:0]  seed_mem [512];
   logic [7:0]  ref_mem  [512];
   logic        load_mem;

   exp_t        exp_q [$];
   int          n_cmp = 0;
   int          n_bad = 0;
   bit          check_en = 1'b0;

   always #5 clk = ~clk;

   wb_sram_bridge #(.BASE_ADDR(BASE)) dut (
      .wb_clk_i   (clk),
      .wb_rst_i   (rst),
      .wbs_cyc_i  (cyc),
      .wbs_stb_i  (stb),
      .wbs_we_i   (we),
      .wbs_sel_i  (sel),
      .wbs_adr_i  (adr),
      .wbs_dat_i  (dat),
      .wbs_ack_o  (wbs_ack_o),
      .wbs_dat_o  (wbs_dat_o),
      .ram_cen_o  (ram_cen_o),
      .ram_gwen_o (ram_gwen_o),
      .ram_wen_o  (ram_wen_o),
      .ram_a_o    (ram_a_o),
      .ram_d_o    (ram_d_o),
      .ram_q_i    (ram_q)
   );

   // Behavioural 512x8 macro: samples on the rising edge while enabled.
   always @(posedge clk) begin
      if (load_mem) begin
         for (int i = 0; i < 512; i++)
            sram[i] <= seed_mem[i];
      end else if (!ram_cen_o) begin
         if (!ram_gwen_o)
            sram[ram_a_o] <= ram_d_o;
         else
            ram_q <= sram[ram_a_o];
      end
   end

   function automatic exp_t idle_rec();
      exp_t r;
      r.cen  = 1'b1;
      r.gwen = 1'b1;
      r.wen  = 8'hFF;
      r.a    = 9'd0;
      r.d    = 8'd0;
      r.ack  = 1'b0;
      r.dat  = 32'd0;
      return r;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Every cycle after reset the DUT pins must match the queued timeline;
   // an empty queue means the bridge must be fully idle.
   initial begin
      exp_t e;
      wait (check_en);
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0)
            e = exp_q.pop_front();
         else
            e = idle_rec();
         checkOutput("ram_cen",  {31'd0, ram_cen_o},  {31'd0, e.cen});
         checkOutput("ram_gwen", {31'd0, ram_gwen_o}, {31'd0, e.gwen});
         checkOutput("ram_wen",  {24'd0, ram_wen_o},  {24'd0, e.wen});
         checkOutput("ram_a",    {23'd0, ram_a_o},    {23'd0, e.a});
         checkOutput("ram_d",    {24'd0, ram_d_o},    {24'd0, e.d});
         checkOutput("ack",      {31'd0, wbs_ack_o},  {31'd0, e.ack});
         checkOutput("dat_o",    wbs_dat_o,           e.dat);
      end
   end

   // mode 0: complete access; 1: reset after two lanes; 2: drop cyc after two lanes.
   task automatic applyStimulus(input int mode, input logic s_we, input logic [3:0] s_sel,
                                input logic [31:0] s_adr, input logic [31:0] s_dat,
                                output logic [31:0] got);
      exp_t        r;
      int          n;
      int          kk;
      logic [31:0] rd;
      logic [8:0]  ba;
      logic        in_win;
      @(negedge clk);
      in_win = (s_adr[31:9] == BASE[31:9]);
      n  = 0;
      kk = 0;
      rd = 32'd0;
      if (in_win) begin
         for (int k = 0; k < 4; k++) begin
            if (s_sel[k] && (mode == 0 || n < 2)) begin
               ba     = {s_adr[8:2], 2'(k)};
               r      = idle_rec();
               r.cen  = 1'b0;
               r.gwen = ~s_we;
               r.wen  = s_we ? 8'h00 : 8'hFF;
               r.a    = ba;
               r.d    = s_dat[8*k +: 8];
               exp_q.push_back(r);
               if (s_we)
                  ref_mem[ba] = s_dat[8*k +: 8];
               n++;
            end
         end
         if (mode == 0) begin
            for (int k = 0; k < 4; k++)
               if (!s_we && s_sel[k])
                  rd[8*k +: 8] = ref_mem[{s_adr[8:2], 2'(k)}];
            kk = (n == 0) ? 1 : (s_we ? n : n + 1);
            for (int i = n; i < kk; i++)
               exp_q.push_back(idle_rec());
            r     = idle_rec();
            r.ack = 1'b1;
            r.dat = s_we ? 32'd0 : rd;
            exp_q.push_back(r);
         end
      end
      cyc = 1'b1;
      stb = 1'b1;
      we  = s_we;
      sel = s_sel;
      adr = s_adr;
      dat = s_dat;
      got = 32'd0;
      if (!in_win) begin
         repeat (10) @(negedge clk);
      end else if (mode == 0) begin
         repeat (kk + 1) @(negedge clk);
         got = wbs_dat_o;
      end else begin
         repeat (2) @(negedge clk);
         if (mode == 1)
            rst = 1'b1;
      end
      cyc = 1'b0;
      stb = 1'b0;
      we  = 1'b0;
      sel = 4'd0;
      adr = 32'd0;
      dat = 32'd0;
      if (mode != 0) begin
         @(negedge clk);
         rst = 1'b0;
      end
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [31:0] got;
      int          m;
      logic [3:0]  rsel;
      logic [31:0] radr;
      for (int i = 0; i < 512; i++) begin
         seed_mem[i] = 8'($urandom);
         ref_mem[i]  = seed_mem[i];
      end
      rst      = 1'b1;
      load_mem = 1'b1;
      cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'd0; adr = 32'd0; dat = 32'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      load_mem = 1'b0;
      checkOutput("reset_ack",   {31'd0, wbs_ack_o}, 32'd0);
      checkOutput("reset_dat_o", wbs_dat_o, 32'd0);
      checkOutput("reset_cen",   {31'd0, ram_cen_o}, 32'd1);
      checkOutput("reset_wen",   {24'd0, ram_wen_o}, 32'h0000_00FF);
      check_en = 1'b1;
      @(negedge clk);
      rst = 1'b0;

      $display("[TB] full-word write and read-back");
      applyStimulus(0, 1'b1, 4'hF, 32'h3000_0010, 32'hDEAD_BEEF, got);
      checkOutput("sram_010", {24'd0, sram[9'h010]}, 32'h0000_00EF);
      checkOutput("sram_011", {24'd0, sram[9'h011]}, 32'h0000_00BE);
      checkOutput("sram_012", {24'd0, sram[9'h012]}, 32'h0000_00AD);
      checkOutput("sram_013", {24'd0, sram[9'h013]}, 32'h0000_00DE);
      applyStimulus(0, 1'b0, 4'hF, 32'h3000_0010, 32'h0, got);
      checkOutput("readback_word", got, 32'hDEAD_BEEF);

      $display("[TB] single-lane write");
      applyStimulus(0, 1'b1, 4'hF, 32'h3000_0004, 32'h5566_7788, got);
      applyStimulus(0, 1'b1, 4'b0100, 32'h3000_0004, 32'h00AA_0000, got);
      applyStimulus(0, 1'b0, 4'hF, 32'h3000_0004, 32'h0, got);
      checkOutput("single_lane_word", got, 32'h55AA_7788);

      $display("[TB] partial read and empty select");
      applyStimulus(0, 1'b0, 4'b0001, 32'h3000_0010, 32'h0, got);
      checkOutput("partial_read", got, 32'h0000_00EF);
      applyStimulus(0, 1'b0, 4'b0000, 32'h3000_0010, 32'h0, got);
      checkOutput("empty_sel_read", got, 32'h0);
      applyStimulus(0, 1'b1, 4'b0000, 32'h3000_0010, 32'h1234_5678, got);
      checkOutput("empty_sel_sram", {24'd0, sram[9'h010]}, 32'h0000_00EF);

      $display("[TB] out of window");
      applyStimulus(0, 1'b1, 4'hF, 32'h3000_0200, 32'hFFFF_FFFF, got);
      applyStimulus(0, 1'b0, 4'hF, 32'h3100_0000, 32'h0, got);

      $display("[TB] top of window");
      applyStimulus(0, 1'b1, 4'hF, 32'h3000_01FC, 32'h0102_0304, got);
      checkOutput("sram_1ff", {24'd0, sram[9'h1FF]}, 32'h0000_0001);
      applyStimulus(0, 1'b0, 4'hF, 32'h3000_01FF, 32'h0, got);
      checkOutput("top_readback", got, 32'h0102_0304);

      $display("[TB] reset mid-write and abort mid-read");
      applyStimulus(0, 1'b1, 4'hF, 32'h3000_0020, 32'h1122_3344, got);
      applyStimulus(1, 1'b1, 4'hF, 32'h3000_0020, 32'hAABB_CCDD, got);
      checkOutput("rst_sram_022", {24'd0, sram[9'h022]}, 32'h0000_0022);
      checkOutput("rst_sram_020", {24'd0, sram[9'h020]}, 32'h0000_00DD);
      applyStimulus(2, 1'b0, 4'hF, 32'h3000_0020, 32'h0, got);
      applyStimulus(0, 1'b0, 4'hF, 32'h3000_0020, 32'h0, got);
      checkOutput("after_abort_read", got, 32'h1122_CCDD);

      $display("[TB] randomized traffic");
      for (int t = 0; t < 80; t++) begin
         m    = ($urandom_range(0, 9) == 0) ? 2 : 0;
         rsel = (m != 0) ? 4'hF : 4'($urandom_range(0, 15));
         if (m == 0 && $urandom_range(0, 11) == 0)
            radr = 32'h4000_0000 | 32'($urandom);
         else
            radr = BASE + 32'($urandom_range(0, 127)) * 32'd4 + 32'($urandom_range(0, 3));
         applyStimulus(m, 1'($urandom_range(0, 1)), rsel, radr, $urandom, got);
      end
      repeat (4) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/wb_sram_bridge.md
# wb_sram_bridge

Wishbone classic slave that maps 32-bit Wishbone word accesses onto the 512x8 single-port GF180 SRAM macro wrapper, replacing the direct bus-to-macro hookup in the user project. Each selected byte lane becomes one serialized byte operation on the macro. Read bytes are gathered into a word register, and a single-cycle `wbs_ack_o` is returned when the access completes. The block sits between the Caravel Wishbone slave ports and `gf180_ram_512x8_wrapper`.

## Interface
- `BASE_ADDR`, default 32'h3000_0000: window base; `wbs_adr_i[31:9]` must equal `BASE_ADDR[31:9]`.
- `wb_clk_i`  in  1  clock; all logic on its rising edge.
- `wb_rst_i`  in  1  reset, synchronous, active-high.
- `wbs_cyc_i`, `wbs_stb_i`, `wbs_we_i`  in  1 each  Wishbone classic controls.
- `wbs_sel_i`  in  4  byte-lane select; lane k = `dat[8k+7:8k]`.
- `wbs_adr_i`  in  32  byte address; bits [1:0] are ignored.
- `wbs_dat_i`  in  32  write data.
- `wbs_ack_o`  out  1  one-cycle acknowledge.
- `wbs_dat_o`  out  32  read data; valid only while ack=1, otherwise 0.
- `ram_cen_o`  out  1  macro chip enable, active-low.
- `ram_gwen_o`  out  1  global write enable, active-low.
- `ram_wen_o`  out  8  per-bit write mask, active-low; always 8'h00 when writing, 8'hFF otherwise.
- `ram_a_o`  out  9  byte address = {`adr[8:2]`, lane}.
- `ram_d_o`  out  8  write byte.
- `ram_q_i`  in  8  macro read data; valid in the cycle after an enabled read edge.

## Operation
- States: IDLE, BUSY, ACK.
- **IDLE**
  - A request is `cyc & stb & hit`, where hit is the window match above.
  - On a request edge: latch `adr[8:2]`, `we`, `sel` into the pending-lane mask, and `dat_i`; clear the read word; go to BUSY.
  - No hit: the block ignores the request (another slave owns it); no ack, no RAM activity.
- **BUSY** (each cycle)
  - Pick the lowest set pending lane and drive the RAM for it: `cen=0`, `a`, `gwen=!we`, `d=dat[lane]`.
  - Clear that lane at the edge.
  - On reads, set `cap_valid` and `cap_lane`; at the following edge load `ram_q_i` into `rdata[cap_lane]`.
  - When no lane is pending, `cap_valid` is clear after this edge, and no lane is issued this cycle → go to ACK.
  - Unselected read lanes return 0.
- **ACK**: drive `ack=1` and `dat_o=rdata` for exactly one cycle, then go to IDLE.
- **Abort**: `cyc` low in BUSY → go to IDLE at the next edge without ack. Bytes already written stay written.
- **Idle RAM values**: `cen=1`, `gwen=1`, `wen=8'hFF`, `a=0`, `d=0`. RAM outputs depend only on registered state, with no combinational path from Wishbone inputs.

## Timing
- Let E0 be the accept edge and n the number of selected lanes.
- **Writes**: lane i is issued in cycle E(i)..E(i+1) (i=0..n−1); the macro samples at E(i+1). Ack is high E(n)..E(n+1) for n≥1.
- **Reads**: the last capture is at E(n+1); ack is high E(n+1)..E(n+2).
- **sel=0**: no RAM enable; ack is high E1..E2.
- **Back-to-back**: the master drops `stb` at the ack edge, so IDLE can accept a new request at the edge after ACK. Minimum gap: one IDLE cycle.
- **Reset values**: state IDLE, `ack=0`, `dat_o=0`, RAM at idle values, pending mask 0, `cap_valid=0`.
- **Reset mid-transaction**: the transaction is abandoned and never acked; `cen=1` in the cycle after the reset edge.
- **Top of window**: `adr` 0x1FC maps to RAM bytes 0x1FC..0x1FF. No wrap is possible because the lane is never added to the word address.

## Structure
- Package `wb_sram_pkg`:
  - state enum (IDLE/BUSY/ACK);
  - `LANES=4`;
  - RAM idle constants: `RAM_WEN_IDLE=8'hFF`, `RAM_WEN_ALL=8'h00`.
- Sub-module `wb_sram_lane_pick`: combinational 4-bit lowest-set-bit picker giving the lane index and a `none` flag.

## Test plan
- **Full-word write and read-back**: write 0xDEADBEEF, sel=F, adr 0x3000_0010.
  - RAM writes A=0x010..0x013 with D=EF, BE, AD, DE; ack at E4 only.
  - Read back with sel=F: `dat_o`=0xDEADBEEF with ack at E5.
- **Single-lane write**: write 0x00AA0000, sel=4'b0100, adr 0x3000_0004.
  - Exactly one RAM write: A=0x006, D=AA.
  - A following full read shows lane2=AA and the other lanes unchanged.
- **Partial read**: read sel=4'b0001 → `dat_o[31:8]`=0, lane0 = stored byte, ack at E2.
- **Empty select**: sel=0 → `cen` stays 1 throughout, ack at E1, `dat_o`=0.
- **Out of window**: adr 0x3000_0200 and 0x3100_0000 → no ack and `cen`=1 for 10 cycles.
- **Reset mid-write**: assert `wb_rst_i` after 2 of 4 lanes of a write.
  - No ack; `cen`=1 next cycle.
  - Bytes 0–1 hold the new data, bytes 2–3 the old data.
- **Abort mid-read**: drop `cyc` after 2 lanes of a read → no ack. The next transaction completes normally.
